// File: rtl/subkey_schedule_ctrl.sv
// subkey_schedule_ctrl
// Sequences Threefish-1024 key-schedule word generation for the Skein core.
// For every subkey s it steps word index i, presenting one word per
// valid/ready handshake. It also presents the key-word index (s+i) mod 17,
// the tweak word index, and the tweak/counter injection strobes.
// Optional feature: define SUBKEY_SCHED_ABORT_EN to add the abort_i input.
// abort_i returns the block to IDLE from RUN or DONE on the next cycle.
module subkey_schedule_ctrl #(
    parameter int NUM_WORDS   = 16,
    parameter int NUM_SUBKEYS = 21
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
`ifdef SUBKEY_SCHED_ABORT_EN
    input  logic       abort_i,
`endif
    input  logic       word_ready_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [4:0] subkey_idx_o,
    output logic [3:0] word_sel_o,
    output logic [4:0] key_idx_o,
    output logic [1:0] tweak_idx_o,
    output logic       tweak_add_o,
    output logic       ctr_add_o,
    output logic       word_valid_o
);

    localparam logic [3:0] LAST_WORD   = 4'(NUM_WORDS - 1);
    localparam logic [3:0] TWEAK0_WORD = 4'(NUM_WORDS - 3);
    localparam logic [3:0] TWEAK1_WORD = 4'(NUM_WORDS - 2);
    localparam logic [4:0] LAST_SUBKEY = 5'(NUM_SUBKEYS - 1);
    // Largest key-word index: the parity word, one past the last key word
    localparam logic [4:0] KEY_MAX     = 5'(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [4:0] subkey;      // s
    logic [3:0] word;        // i
    logic [4:0] key_idx;     // (s+i) mod 17, tracked incrementally
    logic [4:0] key_base;    // s mod 17, the key index at i=0
    logic [1:0] s_mod3;      // s mod 3
    logic [1:0] s1_mod3;     // (s+1) mod 3

    logic       abort;
    logic       handshake;
    logic       last_word;
    logic       clear;
    logic [4:0] key_inc;
    logic [4:0] key_base_inc;

`ifdef SUBKEY_SCHED_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign handshake    = (state == RUN) && word_ready_i;
    assign last_word    = (subkey == LAST_SUBKEY) && (word == LAST_WORD);
    assign key_inc      = (key_idx == KEY_MAX) ? 5'd0 : key_idx + 5'd1;
    assign key_base_inc = (key_base == KEY_MAX) ? 5'd0 : key_base + 5'd1;
    assign s1_mod3      = (s_mod3 == 2'd2) ? 2'd0 : s_mod3 + 2'd1;

    // Counters are cleared when a schedule starts, is aborted, or completes,
    // so IDLE always presents all-zero word outputs
    assign clear = ((state == IDLE) && start_i)
                 || (abort && (state != IDLE))
                 || (handshake && last_word);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs; abort takes priority over handshake
    always_comb begin
        state_nxt    = state;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        word_valid_o = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_o       = 1'b1;
                word_valid_o = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (handshake && last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_o    = 1'b1;
                done_o    = !abort;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Word/subkey counters, key index, and s mod 3 advance on each handshake
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            subkey   <= 5'd0;
            word     <= 4'd0;
            key_idx  <= 5'd0;
            key_base <= 5'd0;
            s_mod3   <= 2'd0;
        end else if (handshake) begin
            if (word == LAST_WORD) begin
                word     <= 4'd0;
                subkey   <= subkey + 5'd1;
                key_base <= key_base_inc;
                key_idx  <= key_base_inc;
                s_mod3   <= s1_mod3;
            end else begin
                word    <= word + 4'd1;
                key_idx <= key_inc;
            end
        end
    end

    assign subkey_idx_o = subkey;
    assign word_sel_o   = word;
    assign key_idx_o    = key_idx;
    assign tweak_add_o  = word_valid_o && ((word == TWEAK0_WORD) || (word == TWEAK1_WORD));
    assign ctr_add_o    = word_valid_o && (word == LAST_WORD);
    assign tweak_idx_o  = (word == TWEAK0_WORD) ? s_mod3  :
                          (word == TWEAK1_WORD) ? s1_mod3 : 2'd0;

endmodule

// File: tb/tb_subkey_schedule_ctrl.sv
// Testbench for subkey_schedule_ctrl.
// The reference model numbers the handshakes n = 0..335 and derives each
// expected word from n: s = n/16 and i = n%16. The key index is (s+i)%17.
// The tweak index is s%3 or (s+1)%3. busy_o, done_o and word_valid_o are
// checked at the same time.
module tb_subkey_schedule_ctrl;

    localparam int NW = 16;
    localparam int NS = 21;
    localparam int TOTAL = NW * NS;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
`ifdef SUBKEY_SCHED_ABORT_EN
    logic       abort_i;
`endif
    logic       word_ready_i;
    logic       busy_o;
    logic       done_o;
    logic [4:0] subkey_idx_o;
    logic [3:0] word_sel_o;
    logic [4:0] key_idx_o;
    logic [1:0] tweak_idx_o;
    logic       tweak_add_o;
    logic       ctr_add_o;
    logic       word_valid_o;

    int checks   = 0;
    int failures = 0;

    subkey_schedule_ctrl #(.NUM_WORDS(NW), .NUM_SUBKEYS(NS)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
`ifdef SUBKEY_SCHED_ABORT_EN
        .abort_i      (abort_i),
`endif
        .word_ready_i (word_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .subkey_idx_o (subkey_idx_o),
        .word_sel_o   (word_sel_o),
        .key_idx_o    (key_idx_o),
        .tweak_idx_o  (tweak_idx_o),
        .tweak_add_o  (tweak_add_o),
        .ctr_add_o    (ctr_add_o),
        .word_valid_o (word_valid_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(busy_o),       0);
        chk({tag, "_done"},  32'(done_o),       0);
        chk({tag, "_valid"}, 32'(word_valid_o), 0);
        chk({tag, "_s"},     32'(subkey_idx_o), 0);
        chk({tag, "_i"},     32'(word_sel_o),   0);
        chk({tag, "_key"},   32'(key_idx_o),    0);
        chk({tag, "_tidx"},  32'(tweak_idx_o),  0);
        chk({tag, "_tadd"},  32'(tweak_add_o),  0);
        chk({tag, "_cadd"},  32'(ctr_add_o),    0);
    endtask

    // Reference word number n from the schedule rules
    task automatic chk_word(input int n);
        int s, i, tidx;
        s = n / NW;
        i = n % NW;
        tidx = (i == 13) ? (s % 3) : (i == 14) ? ((s + 1) % 3) : 0;
        chk("w_busy", 32'(busy_o),       1);
        chk("w_done", 32'(done_o),       0);
        chk("w_s",    32'(subkey_idx_o), 32'(s));
        chk("w_i",    32'(word_sel_o),   32'(i));
        chk("w_key",  32'(key_idx_o),    32'((s + i) % 17));
        chk("w_tidx", 32'(tweak_idx_o),  32'(tidx));
        chk("w_tadd", 32'(tweak_add_o),  32'((i == 13) || (i == 14)));
        chk("w_cadd", 32'(ctr_add_o),    32'(i == 15));
        // Directed boundary points with literal expectations
        if (s == 1 && i == 13) begin
            chk("s1i13_tadd", 32'(tweak_add_o), 1);
            chk("s1i13_tidx", 32'(tweak_idx_o), 1);
        end
        if (s == 1 && i == 14) chk("s1i14_tidx", 32'(tweak_idx_o), 2);
        if (s == 1 && i == 15) begin
            chk("s1i15_cadd", 32'(ctr_add_o), 1);
            chk("s1i15_key",  32'(key_idx_o), 16);
        end
        if (s == 16 && i == 1)  chk("s16i1_key",   32'(key_idx_o),   0);
        if (s == 20 && i == 13) chk("s20i13_tidx", 32'(tweak_idx_o), 2);
        if (s == 20 && i == 14) chk("s20i14_tidx", 32'(tweak_idx_o), 0);
        if (s == 20 && i == 15) chk("s20i15_key",  32'(key_idx_o),   1);
    endtask

    // Runs one schedule. ready_pct is the per-cycle ready probability.
    // poke drives spurious start_i pulses mid-run. stop_at >= 0 returns
    // while word stop_at is presented, before it is handshaken. The start
    // cycle counts as cycle 1.
    task automatic run_sched(input int ready_pct, input bit poke, input int stop_at,
                             output int hs, output int done_cyc, output bit stopped);
        int  n;
        int  cyc;
        bit  pend;
        bit  got;
        n = 0; cyc = 1; pend = 1'b0; got = 1'b0; stopped = 1'b0; done_cyc = -1;
        start_i      = 1'b1;
        word_ready_i = ($urandom_range(99, 0) < ready_pct);
        while (cyc < 5000) begin
            step();
            start_i = 1'b0;
            cyc++;
            if (pend) n++;
            pend = 1'b0;
            if (done_o) begin
                got = 1'b1;
                done_cyc = cyc;
                break;
            end
            chk("run_valid", 32'(word_valid_o), 1);
            if (stop_at >= 0 && n == stop_at) begin
                stopped = 1'b1;
                break;
            end
            chk_word(n);
            word_ready_i = ($urandom_range(99, 0) < ready_pct);
            start_i      = poke && ($urandom_range(4, 0) == 0);
            pend         = word_valid_o && word_ready_i;
        end
        start_i = 1'b0;
        hs = n;
        if (!got && !stopped) begin
            chk("sched_timeout", 32'(got), 1);
        end
        if (got) begin
            step();
            chk("done_width", 32'(done_o), 0);
            chk("done_busy",  32'(busy_o), 0);
            chk("done_valid", 32'(word_valid_o), 0);
        end
    endtask

    initial begin
        int  hs, dc;
        bit  stopped;
        rst_i        = 1'b1;
        start_i      = 1'b0;
        word_ready_i = 1'b0;
`ifdef SUBKEY_SCHED_ABORT_EN
        abort_i      = 1'b0;
`endif
        repeat (3) step();
        chk_idle("reset");
        rst_i = 1'b0;
        word_ready_i = 1'b1;
        step();
        step();
        chk_idle("idle_ready");

        // Full schedule, ready tied high
        run_sched(100, 1'b0, -1, hs, dc, stopped);
        chk("t1_hs",      32'(hs), 32'(TOTAL));
        chk("t1_latency", 32'(dc), 338);

        // Random 30% ready with spurious start pulses
        run_sched(30, 1'b1, -1, hs, dc, stopped);
        chk("t4_hs", 32'(hs), 32'(TOTAL));

        // Reset mid-schedule at s=7, i=5
        run_sched(100, 1'b0, 7 * NW + 5, hs, dc, stopped);
        chk("t5_stopped", 32'(stopped), 1);
        chk("t5_s", 32'(subkey_idx_o), 7);
        chk("t5_i", 32'(word_sel_o),   5);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk_idle("t5_rst");
        run_sched(100, 1'b0, -1, hs, dc, stopped);
        chk("t5_restart_hs", 32'(hs), 32'(TOTAL));

`ifdef SUBKEY_SCHED_ABORT_EN
        // Abort on the final word: handshake is overridden, no done_o
        run_sched(100, 1'b0, TOTAL - 1, hs, dc, stopped);
        chk("t6_stopped", 32'(stopped), 1);
        abort_i      = 1'b1;
        word_ready_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk_idle("t6_abort");
        step();
        chk("t6_no_done", 32'(done_o), 0);
        // abort_i with start_i in IDLE still starts
        abort_i = 1'b1;
        start_i = 1'b1;
        step();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("t6_start_valid", 32'(word_valid_o), 1);
        chk("t6_start_busy",  32'(busy_o), 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
